// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - per-channel rise/fall edge pulses, sticky flags and a saturating event counter
// Optional input debounce filter is compiled in with `define MULTI_EDGE_DETECTOR_DEBOUNCE_EN.
module multi_edge_detector #(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  input  logic               cnt_clr,
  output logic [WIDTH-1:0]   dout,
  output logic [WIDTH-1:0]   sticky,
  output logic               any_pulse,
  output logic [CNT_W-1:0]   evt_cnt
);

  localparam int POP_W = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 1 || WIDTH > 32 || CNT_W < 6 || DEB_CYCLES < 1) begin : g_bad_param
      $error("multi_edge_detector: parameter out of range");
    end
  endgenerate

  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] pulse_nxt;
  logic [POP_W-1:0] pop;
  logic [CNT_W:0]   cnt_sum;

`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic [WIDTH-1:0] filt;
  logic [DEB_W-1:0] stab [WIDTH];

  // filt follows din only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        stab[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (din[i] == filt[i]) begin
          stab[i] <= '0;
        end else if (stab[i] == DEB_W'(DEB_CYCLES - 1)) begin
          filt[i] <= din[i];
          stab[i] <= '0;
        end else begin
          stab[i] <= stab[i] + DEB_W'(1);
        end
      end
    end
  end

  assign det = filt;
`else
  assign det = din;
`endif

  always_comb begin
    pulse_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pulse_nxt[i] = (det[i] & ~prev[i] & mode[2*i]) |
                     (~det[i] & prev[i] & mode[2*i+1]);
    end
  end

  // counter consumes the pulse vector already on dout, hence one cycle behind it
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(dout[i]);
    end
  end

  assign cnt_sum = {1'b0, evt_cnt} + (CNT_W+1)'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= '0;
      dout      <= '0;
      sticky    <= '0;
      any_pulse <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      prev      <= det;
      dout      <= pulse_nxt;
      sticky    <= (sticky & ~clr) | pulse_nxt;
      any_pulse <= |pulse_nxt;
      if (cnt_clr) begin
        evt_cnt <= '0;
      end else if (cnt_sum[CNT_W]) begin
        evt_cnt <= '1;
      end else begin
        evt_cnt <= cnt_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// tb/tb_multi_edge_detector.sv - bench for multi_edge_detector: directed scenarios plus randomized reference-model comparison
`timescale 1ns/1ps
module tb_multi_edge_detector;

  localparam int W    = 8;
  localparam int CW   = 6;
  localparam int DEB  = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
  localparam int LAT    = DEB;
  localparam bit DEB_EN = 1'b1;
`else
  localparam int LAT    = 0;
  localparam bit DEB_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   din = '0;
  logic [2*W-1:0] mode = '0;
  logic [W-1:0]   clr = '0;
  logic           cnt_clr = 1'b0;
  logic [W-1:0]   dout;
  logic [W-1:0]   sticky;
  logic           any_pulse;
  logic [CW-1:0]  evt_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit       m_prev [W];
  bit       m_filt [W];
  int       m_run  [W];
  logic [W-1:0] m_dout = '0;
  logic [W-1:0] m_sticky = '0;
  int       m_cnt = 0;

  always #5 clk = ~clk;

  multi_edge_detector #(.WIDTH(W), .CNT_W(CW), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .clr(clr), .cnt_clr(cnt_clr),
    .dout(dout), .sticky(sticky), .any_pulse(any_pulse), .evt_cnt(evt_cnt)
  );

  function automatic int popc(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_step();
    logic [W-1:0] nd;
    int pop;
    if (reset) begin
      for (int i = 0; i < W; i++) begin
        m_prev[i] = 0; m_filt[i] = 0; m_run[i] = 0;
      end
      m_dout = '0; m_sticky = '0; m_cnt = 0;
      return;
    end
    pop = popc(m_dout);
    if (cnt_clr) m_cnt = 0;
    else m_cnt = (m_cnt + pop > CMAX) ? CMAX : m_cnt + pop;
    nd = '0;
    for (int i = 0; i < W; i++) begin
      bit cur;
      cur = DEB_EN ? m_filt[i] : din[i];
      if (cur != m_prev[i]) nd[i] = cur ? mode[2*i] : mode[2*i+1];
      m_prev[i] = cur;
      if (din[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] >= DEB) begin
          m_filt[i] = din[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_sticky = (m_sticky & ~clr) | nd;
    m_dout = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; din = 8'h01; mode = 16'h5555; clr = '0; cnt_clr = 1'b0;
    repeat (3) tick();
    checks++;
    if (dout !== 0 || sticky !== 0 || evt_cnt !== 0 || any_pulse !== 0) begin
      errors++;
      $display("FAIL reset_hold dout=%h sticky=%h evt_cnt=%0d any=%b expected all zero", dout, sticky, evt_cnt, any_pulse);
    end
    reset = 1'b0;
    for (int c = 0; c < LAT; c++) begin
      tick();
      checks++;
      if (dout !== 8'h00) begin errors++; $display("FAIL reset_early_pulse dout=%h expected 00", dout); end
    end
    tick();
    checks++;
    if (dout !== 8'h01) begin errors++; $display("FAIL reset_release_pulse dout=%h expected 01", dout); end
    checks++;
    if (sticky !== 8'h01) begin errors++; $display("FAIL reset_release_sticky sticky=%h expected 01", sticky); end
    checks++;
    if (any_pulse !== 1'b1) begin errors++; $display("FAIL reset_release_any any=%b expected 1", any_pulse); end
    checks++;
    if (evt_cnt !== 6'd0) begin errors++; $display("FAIL reset_release_cnt evt_cnt=%0d expected 0", evt_cnt); end
    tick();
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_single_pulse dout=%h expected 00", dout); end
    checks++;
    if (evt_cnt !== 6'd1) begin errors++; $display("FAIL reset_count evt_cnt=%0d expected 1", evt_cnt); end
    repeat (3) tick();
    checks++;
    if (dout !== 8'h00 || evt_cnt !== 6'd1) begin
      errors++; $display("FAIL reset_no_repeat dout=%h evt_cnt=%0d expected 00 and 1", dout, evt_cnt);
    end
  endtask

  task automatic test_mixed_modes();
    din = '0; mode = 16'h0039; clr = '1; cnt_clr = 1'b1;
    repeat (LAT + 2) tick();
    clr = '0; cnt_clr = 1'b0; din = 8'h0F;
    repeat (LAT) tick();
    tick();
    checks++;
    if (dout !== 8'h05) begin errors++; $display("FAIL mixed_rise dout=%h expected 05", dout); end
    repeat (2) tick();
    din = 8'h00;
    repeat (LAT) tick();
    tick();
    checks++;
    if (dout !== 8'h06) begin errors++; $display("FAIL mixed_fall dout=%h expected 06", dout); end
    tick();
    checks++;
    if (evt_cnt !== 6'd4) begin errors++; $display("FAIL mixed_count evt_cnt=%0d expected 4", evt_cnt); end
    checks++;
    if (sticky !== 8'h07) begin errors++; $display("FAIL mixed_sticky sticky=%h expected 07", sticky); end
  endtask

  task automatic test_sticky_collision();
    mode = 16'h0030; din = '0; clr = '1;
    repeat (2) tick();
    clr = '0; din = 8'h04;
    repeat (LAT) tick();
    clr = 8'h04;
    tick();
    checks++;
    if (dout !== 8'h04) begin errors++; $display("FAIL collision_pulse dout=%h expected 04", dout); end
    checks++;
    if (sticky !== 8'h04) begin errors++; $display("FAIL collision_set_wins sticky=%h expected 04", sticky); end
    tick();
    checks++;
    if (sticky !== 8'h00) begin errors++; $display("FAIL collision_clear sticky=%h expected 00", sticky); end
    clr = '0;
  endtask

`ifndef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
  task automatic test_saturation();
    int exp;
    mode = 16'hFFFF; din = '0; clr = '0; cnt_clr = 1'b1;
    repeat (2) tick();
    cnt_clr = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      din = ~din;
      tick();
      exp = (8 * (n - 1) > CMAX) ? CMAX : 8 * (n - 1);
      checks++;
      if (dout !== 8'hFF) begin errors++; $display("FAIL sat_toggle_pulse n=%0d dout=%h expected ff", n, dout); end
      checks++;
      if (evt_cnt !== CW'(exp)) begin errors++; $display("FAIL sat_count n=%0d evt_cnt=%0d expected %0d", n, evt_cnt, exp); end
    end
    din = ~din; cnt_clr = 1'b1;
    tick();
    checks++;
    if (evt_cnt !== 6'd0) begin errors++; $display("FAIL sat_clear evt_cnt=%0d expected 0", evt_cnt); end
    din = ~din; cnt_clr = 1'b0;
    tick();
    checks++;
    if (evt_cnt !== 6'd8) begin errors++; $display("FAIL sat_after_clear evt_cnt=%0d expected 8", evt_cnt); end
  endtask
`endif

  task automatic test_debounce();
    int pulses;
    int seen_at;
    mode = 16'h0001; din = '0; clr = '1; cnt_clr = 1'b1;
    repeat (LAT + 3) tick();
    clr = '0; cnt_clr = 1'b0;
    pulses = 0;
    din = 8'h01;
    repeat (3) begin tick(); pulses += int'(dout[0]); end
    din = 8'h00;
    repeat (LAT + 4) begin tick(); pulses += int'(dout[0]); end
    checks++;
    if (pulses != (DEB_EN ? 0 : 1)) begin
      errors++; $display("FAIL glitch_pulses got=%0d expected %0d", pulses, DEB_EN ? 0 : 1);
    end
    din = 8'h01;
    seen_at = -1;
    for (int c = 1; c <= 20 && seen_at < 0; c++) begin
      tick();
      if (dout[0]) seen_at = c;
    end
    checks++;
    if (seen_at != LAT + 1) begin errors++; $display("FAIL stable_latency got=%0d expected %0d", seen_at, LAT + 1); end
    pulses = 0;
    repeat (6) begin tick(); pulses += int'(dout[0]); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL stable_single_pulse extra=%0d expected 0", pulses); end
  endtask

  task automatic test_reset_midstream();
    mode = 16'h0001; din = '0;
    repeat (LAT + 2) tick();
    din = 8'h01;
    repeat (LAT) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (dout !== 0 || sticky !== 0 || evt_cnt !== 0 || any_pulse !== 0) begin
      errors++;
      $display("FAIL midreset dout=%h sticky=%h evt_cnt=%0d any=%b expected all zero", dout, sticky, evt_cnt, any_pulse);
    end
    din = '0; reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (dout !== 0 || sticky !== 0 || evt_cnt !== 0) begin
      errors++;
      $display("FAIL midreset_dropped dout=%h sticky=%h evt_cnt=%0d expected all zero", dout, sticky, evt_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      din = din ^ W'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) mode = (2*W)'($urandom);
      clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      cnt_clr = ($urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (dout !== m_dout) begin errors++; $display("FAIL rnd_dout cyc=%0d got=%h expected %h", c, dout, m_dout); end
      checks++;
      if (sticky !== m_sticky) begin errors++; $display("FAIL rnd_sticky cyc=%0d got=%h expected %h", c, sticky, m_sticky); end
      checks++;
      if (any_pulse !== (|m_dout)) begin errors++; $display("FAIL rnd_any cyc=%0d got=%b expected %b", c, any_pulse, |m_dout); end
      checks++;
      if (evt_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d expected %0d", c, evt_cnt, m_cnt); end
    end
    reset = 1'b0; clr = '0; cnt_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mixed_modes();
    test_sticky_collision();
`ifndef MULTI_EDGE_DETECTOR_DEBOUNCE_EN
    test_saturation();
`endif
    test_debounce();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
